// File: rtl/sub96_pipe.sv
// Pipelined 96-bit subtractor: a_in - b_in - borrow_in as NUM_SEG registered borrow-ripple segments.
// Define SUB96_MODCORR_EN to add a final stage that adds MODULUS to borrowing results.
module sub96_pipe #(
    parameter int unsigned SEG_WIDTH = 24,
    parameter int unsigned NUM_SEG   = 4,
    parameter logic [SEG_WIDTH*NUM_SEG-1:0] MODULUS = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEG_WIDTH*NUM_SEG-1:0] a_in,
    input  logic [SEG_WIDTH*NUM_SEG-1:0] b_in,
    input  logic                         borrow_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEG_WIDTH*NUM_SEG-1:0] diff,
    output logic                         borrow_out
);

    localparam int unsigned W = SEG_WIDTH * NUM_SEG;

    // Returns {borrow, difference} for one segment.
    function automatic logic [SEG_WIDTH:0] seg_sub(
        input logic [SEG_WIDTH-1:0] a,
        input logic [SEG_WIDTH-1:0] b,
        input logic                 bin
    );
        return {1'b0, a} - {1'b0, b} - {{SEG_WIDTH{1'b0}}, bin};
    endfunction

    logic adv;

    // acc holds finished difference segments below the stage and pending minuend segments above it.
    logic [W-1:0]         acc_q  [NUM_SEG];
    logic [W-1:0]         acc_d  [NUM_SEG];
    logic [W-1:0]         sub_q  [NUM_SEG-1];
    logic [W-1:0]         sub_d  [NUM_SEG-1];
    logic [NUM_SEG-1:0]   bo_q, bo_d;
    logic [NUM_SEG-1:0]   vld_q, vld_d;

    logic [W-1:0]         src_acc [NUM_SEG];
    logic [W-1:0]         src_sub [NUM_SEG];
    logic [NUM_SEG-1:0]   src_bo, src_vld;
    logic [SEG_WIDTH:0]   seg_res [NUM_SEG];

    always_comb begin
        src_acc[0] = a_in;
        src_sub[0] = b_in;
        src_bo[0]  = borrow_in;
        src_vld[0] = in_valid;
        for (int k = 1; k < NUM_SEG; k++) begin
            src_acc[k] = acc_q[k-1];
            src_sub[k] = sub_q[k-1];
            src_bo[k]  = bo_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    // Stage k boundary: subtract segment k and splice it into the accumulated word.
    always_comb begin
        for (int k = 0; k < NUM_SEG; k++) begin
            seg_res[k] = seg_sub(src_acc[k][k*SEG_WIDTH +: SEG_WIDTH],
                                 src_sub[k][k*SEG_WIDTH +: SEG_WIDTH],
                                 src_bo[k]);
            acc_d[k] = src_acc[k];
            acc_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_res[k][SEG_WIDTH-1:0];
            bo_d[k]  = seg_res[k][SEG_WIDTH];
            vld_d[k] = src_vld[k];
        end
        for (int k = 0; k < NUM_SEG - 1; k++) begin
            sub_d[k] = src_sub[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            bo_q  <= '0;
            for (int k = 0; k < NUM_SEG; k++) begin
                acc_q[k] <= '0;
            end
            for (int k = 0; k < NUM_SEG - 1; k++) begin
                sub_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            bo_q  <= bo_d;
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

`ifdef SUB96_MODCORR_EN
    logic         mc_vld_q, mc_vld_d;
    logic         mc_bo_q, mc_bo_d;
    logic [W-1:0] mc_diff_q, mc_diff_d;

    // Correction stage boundary: fold a borrowing result back into the field.
    always_comb begin
        mc_vld_d  = vld_q[NUM_SEG-1];
        mc_bo_d   = bo_q[NUM_SEG-1];
        mc_diff_d = acc_q[NUM_SEG-1] + (bo_q[NUM_SEG-1] ? MODULUS : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc_vld_q  <= 1'b0;
            mc_bo_q   <= 1'b0;
            mc_diff_q <= '0;
        end else if (adv) begin
            mc_vld_q  <= mc_vld_d;
            mc_bo_q   <= mc_bo_d;
            mc_diff_q <= mc_diff_d;
        end
    end

    assign out_valid  = mc_vld_q;
    assign diff       = mc_diff_q;
    assign borrow_out = mc_bo_q;
`else
    // MODULUS has no role in the plain two's-complement build.
    logic unused_modulus;
    assign unused_modulus = ^MODULUS;

    assign out_valid  = vld_q[NUM_SEG-1];
    assign diff       = acc_q[NUM_SEG-1];
    assign borrow_out = bo_q[NUM_SEG-1];
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

endmodule

// File: tb/tb_sub96_pipe.sv
// Self-checking bench for sub96_pipe: arithmetic scoreboard plus directed literal vectors.
module tb_sub96_pipe;

    localparam logic [95:0] M = 96'hFFFFFFFF00000001;
`ifdef SUB96_MODCORR_EN
    localparam int          LAT      = 5;
    localparam logic [95:0] EXP_WRAP = 96'hFFFFFFFF00000000;
`else
    localparam int          LAT      = 4;
    localparam logic [95:0] EXP_WRAP = {96{1'b1}};
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] a_in;
    logic [95:0] b_in;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] diff;
    logic        borrow_out;

    int tests;
    int fails;
    logic [96:0] exp_q[$];

    sub96_pipe #(
        .SEG_WIDTH(24),
        .NUM_SEG  (4),
        .MODULUS  (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result as {borrow, diff} straight from the arithmetic definition.
    function automatic logic [96:0] model(input logic [95:0] a, input logic [95:0] b, input logic bin);
        logic [96:0] r;
        r = {1'b0, a} - {1'b0, b} - {96'd0, bin};
`ifdef SUB96_MODCORR_EN
        if (r[96]) r[95:0] = r[95:0] + M;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [96:0] act, input logic [96:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        prev_hold;
        logic [95:0] prev_diff;
        logic        prev_bo;
        logic [96:0] e;
        prev_hold = 1'b0;
        prev_diff = '0;
        prev_bo   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_hold = 1'b0;
            end else begin
                chk("in_ready_adv", {96'd0, in_ready}, {96'd0, (!out_valid || out_ready)});
                if (prev_hold)
                    chk("stall_stable", {borrow_out, diff}, {prev_bo, prev_diff});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out: got out_valid with diff %h, expected no result", diff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("scoreboard", {borrow_out, diff}, e);
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(a_in, b_in, borrow_in));
                prev_hold = out_valid && !out_ready;
                prev_diff = diff;
                prev_bo   = borrow_out;
            end
        end
    endtask

    task automatic send_one(input string name, input logic [95:0] a, input logic [95:0] b,
                            input logic bin, input logic [95:0] exp_d, input logic exp_bo);
        int edges;
        a_in      = a;
        b_in      = b;
        borrow_in = bin;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({name, "_latency"}, 97'(edges), 97'(LAT));
        chk({name, "_diff"}, {1'b0, diff}, {1'b0, exp_d});
        chk({name, "_borrow"}, {96'd0, borrow_out}, {96'd0, exp_bo});
    endtask

    initial begin
        logic [3:0] ready_pat;
        int         idx;
        int         cyc;
        logic       take;

        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        borrow_in = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_out_valid", {96'd0, out_valid}, 97'd0);
        chk("reset_diff", {1'b0, diff}, 97'd0);
        chk("reset_borrow", {96'd0, borrow_out}, 97'd0);
        chk("reset_in_ready", {96'd0, in_ready}, 97'd1);

        send_one("basic", 96'h5, 96'h3, 1'b0, 96'h2, 1'b0);
        send_one("cross_seg", 96'h1_000000_000000, 96'h1, 1'b0, 96'h0_FFFFFF_FFFFFF, 1'b0);
        send_one("wrap", 96'h0, 96'h1, 1'b0, EXP_WRAP, 1'b1);
        send_one("borrow_in", 96'h0, 96'h0, 1'b1, EXP_WRAP, 1'b1);
        send_one("top_seg", 96'h123456789ABCDEF012345678, 96'h023456789ABCDEF012345678, 1'b0,
                 96'h100000000000000000000000, 1'b0);
        send_one("all_ones", {96{1'b1}}, 96'h0, 1'b1, {{95{1'b1}}, 1'b0}, 1'b0);

        // Eight back-to-back operands while the sink stalls in a 1,0,0,1 pattern.
        ready_pat = 4'b1001;
        idx = 0;
        cyc = 0;
        while (cyc < 200 && (idx < 8 || exp_q.size() != 0)) begin
            out_ready = ready_pat[cyc % 4];
            if (idx < 8) begin
                in_valid  = 1'b1;
                a_in      = {32'h11111111 * idx, 32'h0, 32'h5};
                b_in      = {32'h08080808, 32'h0 + idx, 32'h6};
                borrow_in = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take) idx++;
            cyc++;
        end
        chk("stall_drain", {idx[31:0], 65'(exp_q.size())}, {32'd8, 65'd0});
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Three items in flight, then a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            a_in      = 96'h100 + 96'(i);
            b_in      = 96'h1;
            borrow_in = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_out_valid", {96'd0, out_valid}, 97'd0);
        chk("midrst_diff", {1'b0, diff}, 97'd0);
        chk("midrst_borrow", {96'd0, borrow_out}, 97'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_out", {96'd0, out_valid}, 97'd0);
        end
        send_one("post_reset", 96'h10, 96'h7, 1'b1, 96'h8, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 97'(exp_q.size()), 97'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
